// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter
//   Owns the framebuffer write port and shares it between two pixel writers
//   (port 0: draw engine, port 1: PS/CPU bridge) using round-robin
//   valid/ready arbitration. A built-in clear sequencer fills every pixel with
//   CLEAR_VALUE, one write per cycle, and takes priority over both writers.
//   Lives entirely in the write-clock domain, directly in front of the RAM.
//
// Ports
//   clk_wr        write clock (sole clock)
//   rst           asynchronous reset, active-high
//   valid0/1      requester n has a pixel write pending
//   addr0/1       requester n pixel address
//   data0/1       requester n pixel value
//   ready0/1      combinational grant; transfer on an edge where valid & ready
//   clear_start   single-cycle pulse starting a full-frame clear
//   clear_busy    high for every cycle a clear write is presented
//   clear_done    single-cycle pulse alongside the last clear write
//   oob_err       single-cycle pulse: accepted write had addr >= NUM_PIX
//   en_wr/wrea    framebuffer write enable / strobe (identical)
//   addr_wr/din   framebuffer write address / data
module fb_write_arbiter #(
  parameter int unsigned            FRAME_WIDTH    = 640,
  parameter int unsigned            FRAME_HEIGHT   = 480,
  parameter int unsigned            SCALING_FACTOR = 1,
  parameter int unsigned            ADDR_WIDTH     = 19,
  parameter int unsigned            DATA_WIDTH     = 8,
  parameter logic [DATA_WIDTH-1:0]  CLEAR_VALUE    = '0
) (
  input  logic                  clk_wr,
  input  logic                  rst,
  input  logic                  valid0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] data0,
  output logic                  ready0,
  input  logic                  valid1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] data1,
  output logic                  ready1,
  input  logic                  clear_start,
  output logic                  clear_busy,
  output logic                  clear_done,
  output logic                  oob_err,
  output logic                  en_wr,
  output logic                  wrea,
  output logic [ADDR_WIDTH-1:0] addr_wr,
  output logic [DATA_WIDTH-1:0] din
);

  localparam int unsigned NUM_PIX =
    (FRAME_WIDTH / SCALING_FACTOR) * (FRAME_HEIGHT / SCALING_FACTOR);
  localparam logic [ADDR_WIDTH:0]   LP_NUM_PIX = (ADDR_WIDTH+1)'(NUM_PIX);
  localparam logic [ADDR_WIDTH-1:0] LP_LAST    = ADDR_WIDTH'(NUM_PIX - 1);

  if (64'(NUM_PIX) > (64'd1 << ADDR_WIDTH)) begin : g_addr_width_check
    $error("fb_write_arbiter: ADDR_WIDTH too small for frame size");
  end

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_en_wr, w_en_nxt;
  logic [ADDR_WIDTH-1:0] r_addr_wr, w_addr_nxt;
  logic [DATA_WIDTH-1:0] r_din, w_din_nxt;
  logic                  r_oob, w_oob_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_done, w_done_nxt;
  logic [ADDR_WIDTH-1:0] r_clr_cnt, w_cnt_nxt;
  logic                  r_rr, w_rr_nxt;

  logic                  w_ready0, w_ready1;
  logic                  w_xfer, w_gnt, w_oob, w_issue_clr, w_clr_last;
  logic [ADDR_WIDTH-1:0] w_gnt_addr, w_clr_addr;
  logic [DATA_WIDTH-1:0] w_gnt_data;

  // r_rr holds the last granted port; on contention the other port wins.
  always_comb begin
    w_ready0 = 1'b0;
    w_ready1 = 1'b0;
    if (!rst && r_state == ST_IDLE && !clear_start) begin
      if (valid0 && valid1) begin
        w_ready0 = r_rr;
        w_ready1 = ~r_rr;
      end else begin
        w_ready0 = valid0;
        w_ready1 = valid1;
      end
    end
  end

  assign w_xfer     = (valid0 & w_ready0) | (valid1 & w_ready1);
  assign w_gnt      = w_ready1;
  assign w_gnt_addr = w_gnt ? addr1 : addr0;
  assign w_gnt_data = w_gnt ? data1 : data0;
  assign w_oob      = {1'b0, w_gnt_addr} >= LP_NUM_PIX;

  // The first clear write (address 0) is issued straight from IDLE, so the
  // counter always holds the next address to issue while in CLEAR.
  assign w_clr_addr = (r_state == ST_CLEAR) ? r_clr_cnt : '0;
  assign w_clr_last = (w_clr_addr == LP_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_en_nxt    = 1'b0;
    w_addr_nxt  = r_addr_wr;
    w_din_nxt   = r_din;
    w_oob_nxt   = 1'b0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_cnt_nxt   = r_clr_cnt;
    w_rr_nxt    = r_rr;
    w_issue_clr = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (clear_start) begin
          w_issue_clr = 1'b1;
        end else if (w_xfer) begin
          w_rr_nxt = w_gnt;
          if (w_oob) begin
            w_oob_nxt = 1'b1;
          end else begin
            w_en_nxt   = 1'b1;
            w_addr_nxt = w_gnt_addr;
            w_din_nxt  = w_gnt_data;
          end
        end
      end
      ST_CLEAR: w_issue_clr = 1'b1;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (w_issue_clr) begin
      w_en_nxt   = 1'b1;
      w_addr_nxt = w_clr_addr;
      w_din_nxt  = CLEAR_VALUE;
      w_busy_nxt = 1'b1;
      if (w_clr_last) begin
        w_done_nxt  = 1'b1;
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end else begin
        w_state_nxt = ST_CLEAR;
        w_cnt_nxt   = w_clr_addr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_wr or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_en_wr   <= 1'b0;
      r_addr_wr <= '0;
      r_din     <= '0;
      r_oob     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_clr_cnt <= '0;
      r_rr      <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_en_wr   <= w_en_nxt;
      r_addr_wr <= w_addr_nxt;
      r_din     <= w_din_nxt;
      r_oob     <= w_oob_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_clr_cnt <= w_cnt_nxt;
      r_rr      <= w_rr_nxt;
    end
  end

  assign ready0     = w_ready0;
  assign ready1     = w_ready1;
  assign en_wr      = r_en_wr;
  assign wrea       = r_en_wr;
  assign addr_wr    = r_addr_wr;
  assign din        = r_din;
  assign oob_err    = r_oob;
  assign clear_busy = r_busy;
  assign clear_done = r_done;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb_fb_write_arbiter
//   Self-checking bench for fb_write_arbiter on an 8x4 frame (32 pixels).
//   ADDR_WIDTH is 6 so that addresses >= 32 can actually be presented.
module tb_fb_write_arbiter;

  localparam int AW   = 6;
  localparam int DW   = 8;
  localparam int NPIX = 32;

  logic          clk_wr = 1'b0;
  logic          rst = 1'b0;
  logic          valid0 = 1'b0, valid1 = 1'b0, clear_start = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] data0 = '0, data1 = '0;
  logic          ready0, ready1, clear_busy, clear_done, oob_err, en_wr, wrea;
  logic [AW-1:0] addr_wr;
  logic [DW-1:0] din;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  // Reference model state: last granted port and last written pixel.
  int            m_last;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;

  fb_write_arbiter #(
    .FRAME_WIDTH(8), .FRAME_HEIGHT(4), .SCALING_FACTOR(1),
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLEAR_VALUE(8'h00)
  ) dut (
    .clk_wr(clk_wr), .rst(rst),
    .valid0(valid0), .addr0(addr0), .data0(data0), .ready0(ready0),
    .valid1(valid1), .addr1(addr1), .data1(data1), .ready1(ready1),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
    .oob_err(oob_err), .en_wr(en_wr), .wrea(wrea), .addr_wr(addr_wr), .din(din)
  );

  always #5 clk_wr = ~clk_wr;

  task automatic do_reset();
    rst = 1'b1; valid0 = 1'b0; valid1 = 1'b0; clear_start = 1'b0;
    repeat (2) @(posedge clk_wr);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [19:0] got;
    #1 rst = 1'b1;
    valid0 = 1'b1; addr0 = 6'd5; data0 = 8'hAA; valid1 = 1'b0;
    @(posedge clk_wr); #1;
    got = {ready0, ready1, en_wr, wrea, oob_err, clear_busy, clear_done, addr_wr, din};
    tot_cnt++;
    if (got !== '0) $display("FAIL reset_outputs got=%h exp=0", got); else pass_cnt++;
    rst = 1'b0; #1;
    tot_cnt++;
    if ({ready0, ready1} !== 2'b10) $display("FAIL reset_ready got=%b exp=10", {ready0, ready1});
    else pass_cnt++;
    @(posedge clk_wr); #1; valid0 = 1'b0;
    tot_cnt++;
    if ({en_wr, wrea, addr_wr, din} !== {1'b1, 1'b1, 6'd5, 8'hAA})
      $display("FAIL first_write got=%h exp=%h", {en_wr, wrea, addr_wr, din}, {1'b1, 1'b1, 6'd5, 8'hAA});
    else pass_cnt++;
    @(posedge clk_wr); #1;
    tot_cnt++;
    if ({en_wr, wrea, addr_wr, din} !== {1'b0, 1'b0, 6'd5, 8'hAA})
      $display("FAIL idle_hold got=%h exp=%h", {en_wr, wrea, addr_wr, din}, {1'b0, 1'b0, 6'd5, 8'hAA});
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [15:0] exp_w;
    do_reset();
    valid0 = 1'b1; addr0 = 6'd3; data0 = 8'h31;
    valid1 = 1'b1; addr1 = 6'd7; data1 = 8'h72;
    for (int i = 0; i < 4; i++) begin
      #1;
      tot_cnt++;
      if ({ready0, ready1} !== ((i % 2 == 0) ? 2'b10 : 2'b01))
        $display("FAIL rr_ready%0d got=%b exp=%b", i, {ready0, ready1}, (i % 2 == 0) ? 2'b10 : 2'b01);
      else pass_cnt++;
      @(posedge clk_wr); #1;
      if (i == 3) begin valid0 = 1'b0; valid1 = 1'b0; end
      exp_w = (i % 2 == 0) ? {1'b1, 1'b1, 6'd3, 8'h31} : {1'b1, 1'b1, 6'd7, 8'h72};
      tot_cnt++;
      if ({en_wr, wrea, addr_wr, din} !== exp_w)
        $display("FAIL rr_write%0d got=%h exp=%h", i, {en_wr, wrea, addr_wr, din}, exp_w);
      else pass_cnt++;
    end
    @(posedge clk_wr); #1;
    tot_cnt++;
    if (en_wr !== 1'b0) $display("FAIL rr_end got=%b exp=0", en_wr); else pass_cnt++;
  endtask

  task automatic test_clear();
    logic [16:0] exp_w;
    do_reset();
    clear_start = 1'b1;
    for (int i = 0; i < NPIX; i++) begin
      @(posedge clk_wr); #1;
      clear_start = (i == 10);
      exp_w = {1'b1, 6'(i), 8'h00, 1'b1, (i == NPIX - 1)};
      tot_cnt++;
      if ({en_wr, addr_wr, din, clear_busy, clear_done} !== exp_w)
        $display("FAIL clear_step%0d got=%h exp=%h", i, {en_wr, addr_wr, din, clear_busy, clear_done}, exp_w);
      else pass_cnt++;
    end
    @(posedge clk_wr); #1;
    tot_cnt++;
    if ({en_wr, clear_busy, clear_done} !== 3'b000)
      $display("FAIL clear_end got=%b exp=000", {en_wr, clear_busy, clear_done});
    else pass_cnt++;
  endtask

  task automatic test_clear_vs_valid();
    do_reset();
    clear_start = 1'b1; valid1 = 1'b1; addr1 = 6'd9; data1 = 8'h5C;
    #1;
    tot_cnt++;
    if ({ready0, ready1} !== 2'b00) $display("FAIL cv_start_ready got=%b exp=00", {ready0, ready1});
    else pass_cnt++;
    for (int i = 0; i < NPIX; i++) begin
      @(posedge clk_wr); #1;
      clear_start = 1'b0; #1;
      tot_cnt++;
      if ({addr_wr, clear_busy, clear_done, ready1} !== {6'(i), 1'b1, (i == NPIX - 1), (i == NPIX - 1)})
        $display("FAIL cv_step%0d got=%h exp=%h", i, {addr_wr, clear_busy, clear_done, ready1},
                 {6'(i), 1'b1, (i == NPIX - 1), (i == NPIX - 1)});
      else pass_cnt++;
    end
    @(posedge clk_wr); #1; valid1 = 1'b0;
    tot_cnt++;
    if ({en_wr, wrea, addr_wr, din, clear_busy} !== {1'b1, 1'b1, 6'd9, 8'h5C, 1'b0})
      $display("FAIL cv_write got=%h exp=%h", {en_wr, wrea, addr_wr, din, clear_busy}, {1'b1, 1'b1, 6'd9, 8'h5C, 1'b0});
    else pass_cnt++;
  endtask

  task automatic test_oob();
    do_reset();
    valid1 = 1'b1; addr1 = 6'd32; data1 = 8'h11;
    #1;
    tot_cnt++;
    if (ready1 !== 1'b1) $display("FAIL oob_ready got=%b exp=1", ready1); else pass_cnt++;
    @(posedge clk_wr); #1;
    valid1 = 1'b0; valid0 = 1'b1; addr0 = 6'd31; data0 = 8'h3F;
    tot_cnt++;
    if ({en_wr, wrea, oob_err} !== 3'b001) $display("FAIL oob_pulse got=%b exp=001", {en_wr, wrea, oob_err});
    else pass_cnt++;
    @(posedge clk_wr); #1; valid0 = 1'b0;
    tot_cnt++;
    if ({en_wr, oob_err, addr_wr, din} !== {1'b1, 1'b0, 6'd31, 8'h3F})
      $display("FAIL oob_edge31 got=%h exp=%h", {en_wr, oob_err, addr_wr, din}, {1'b1, 1'b0, 6'd31, 8'h3F});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_clear();
    bit found = 0;
    int cyc = 0;
    do_reset();
    clear_start = 1'b1;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk_wr); #1; clear_start = 1'b0;
      if (en_wr === 1'b1 && addr_wr === 6'd12) found = 1;
    end
    tot_cnt++;
    if (!found) $display("FAIL mid_reach12 got=%0d exp=12", addr_wr); else pass_cnt++;
    rst = 1'b1; #1;
    tot_cnt++;
    if ({en_wr, wrea, oob_err, clear_busy, clear_done, addr_wr, din} !== '0)
      $display("FAIL mid_rst_outputs got=%h exp=0", {en_wr, wrea, oob_err, clear_busy, clear_done, addr_wr, din});
    else pass_cnt++;
    repeat (2) @(posedge clk_wr); #1;
    tot_cnt++;
    if ({clear_busy, clear_done} !== 2'b00) $display("FAIL mid_rst_hold got=%b exp=00", {clear_busy, clear_done});
    else pass_cnt++;
    rst = 1'b0; clear_start = 1'b1;
    @(posedge clk_wr); #1; clear_start = 1'b0;
    tot_cnt++;
    if ({en_wr, addr_wr, clear_busy} !== {1'b1, 6'd0, 1'b1})
      $display("FAIL mid_restart got=%h exp=%h", {en_wr, addr_wr, clear_busy}, {1'b1, 6'd0, 1'b1});
    else pass_cnt++;
    found = 0;
    while (!found && cyc < 40) begin
      @(posedge clk_wr); #1; cyc++;
      if (clear_done === 1'b1) found = 1;
    end
    tot_cnt++;
    if (!found || cyc != NPIX - 1 || addr_wr !== 6'd31)
      $display("FAIL mid_redone got=cyc%0d/addr%0d exp=cyc31/addr31", cyc, addr_wr);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int g, ga;
    logic [DW-1:0] gd;
    logic exp_en, exp_oob;
    do_reset();
    m_last = 1; m_addr = '0; m_din = '0;
    for (int n = 0; n < 300; n++) begin
      valid0 = ($urandom_range(0, 3) != 0);
      valid1 = ($urandom_range(0, 3) != 0);
      addr0  = 6'($urandom_range(0, 39));
      addr1  = 6'($urandom_range(0, 39));
      data0  = 8'($urandom);
      data1  = 8'($urandom);
      if (valid0 && valid1) g = (m_last == 0) ? 1 : 0;
      else if (valid0)      g = 0;
      else if (valid1)      g = 1;
      else                  g = -1;
      #1;
      tot_cnt++;
      if ({ready0, ready1} !== {g == 0, g == 1})
        $display("FAIL rnd_ready%0d got=%b exp=%b", n, {ready0, ready1}, {g == 0, g == 1});
      else pass_cnt++;
      exp_en = 1'b0; exp_oob = 1'b0;
      if (g >= 0) begin
        ga = (g == 1) ? int'(addr1) : int'(addr0);
        gd = (g == 1) ? data1 : data0;
        m_last = g;
        if (ga < NPIX) begin
          exp_en = 1'b1; m_addr = 6'(ga); m_din = gd;
        end else begin
          exp_oob = 1'b1;
        end
      end
      @(posedge clk_wr); #1;
      tot_cnt++;
      if ({en_wr, wrea, oob_err, addr_wr, din} !== {exp_en, exp_en, exp_oob, m_addr, m_din})
        $display("FAIL rnd_write%0d got=%h exp=%h", n, {en_wr, wrea, oob_err, addr_wr, din},
                 {exp_en, exp_en, exp_oob, m_addr, m_din});
      else pass_cnt++;
    end
    valid0 = 1'b0; valid1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_clear();
    test_clear_vs_valid();
    test_oob();
    test_reset_mid_clear();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
